// File: rtl/uart_cmd_parser_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_cmd_parser_pkg : frame states and constants shared by the UART parser
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_CKSUM = 3'd4
  } state_e;

  localparam int         MAX_LEN       = 4;
  localparam logic [7:0] HEADER_DEF    = 8'h55;
  localparam logic [7:0] BAUD_ADDR_DEF = 8'hFE;

  function automatic logic len_ok(input logic [7:0] len);
    return (len != 8'd0) && (len <= 8'(MAX_LEN));
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parser_timeout.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_cmd_parser_timeout : up-counter with clear/enable, pulses at LIMIT-1
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_cmd_parser_timeout #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int           W   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] TOP = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  // A clear on the same cycle suppresses the terminal count.
  assign tc_o = en_i && !clr_i && (cnt_q == TOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i || tc_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_cmd_parser : UART command frames -> DDS config writes / baud retune
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int         CLOCK_FREQ   = 100_000_000,
  parameter int         BAUD_WIDTH   = 20,
  parameter int         DEFAULT_BAUD = 115200,
  parameter int         MAX_BAUD     = 921600,
  parameter int         TIMEOUT_CYC  = 1_000_000,
  parameter logic [7:0] HEADER       = HEADER_DEF,
  parameter logic [7:0] BAUD_ADDR    = BAUD_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_rec,
  output logic                  rx_clr,
  output logic [BAUD_WIDTH-1:0] baud_var,
  output logic                  baud_upd,
  output logic [7:0]            cfg_addr,
  output logic [31:0]           cfg_data,
  output logic                  cfg_wr,
  output logic                  busy,
  output logic                  err_cksum,
  output logic                  err_frame,
  output logic                  err_timeout
);

  if (CLOCK_FREQ < 16 * MAX_BAUD) begin : g_clk_check
    $error("CLOCK_FREQ cannot oversample MAX_BAUD");
  end

  state_e                state_q;
  logic [7:0]            addr_q, xor_q;
  logic [31:0]           data_q;
  logic [2:0]            rem_q;
  logic                  rx_clr_q, cfg_wr_q, baud_upd_q;
  logic                  err_ck_q, err_fr_q, err_to_q;
  logic [7:0]            cfg_addr_q;
  logic [31:0]           cfg_data_q;
  logic [BAUD_WIDTH-1:0] baud_q;

  logic        take, to_tc, baud_ok;
  logic [31:0] data_d;
  logic [7:0]  xor_d;

  // The stale rx_rec during the clear cycle must not be taken twice.
  assign take    = rx_rec && !rx_clr_q;
  assign data_d  = {data_q[23:0], rx_data};
  assign xor_d   = xor_q ^ rx_data;
  assign baud_ok = (data_q != 32'd0) && (data_q <= 32'(MAX_BAUD));

  uart_cmd_parser_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (take),
    .en_i  (state_q != S_HUNT),
    .tc_o  (to_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_HUNT;
      addr_q     <= '0;
      xor_q      <= '0;
      data_q     <= '0;
      rem_q      <= '0;
      rx_clr_q   <= 1'b0;
      cfg_wr_q   <= 1'b0;
      baud_upd_q <= 1'b0;
      err_ck_q   <= 1'b0;
      err_fr_q   <= 1'b0;
      err_to_q   <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      baud_q     <= BAUD_WIDTH'(DEFAULT_BAUD);
    end else begin
      rx_clr_q   <= take;
      cfg_wr_q   <= 1'b0;
      baud_upd_q <= 1'b0;
      err_ck_q   <= 1'b0;
      err_fr_q   <= 1'b0;
      err_to_q   <= 1'b0;
      if (to_tc) begin
        state_q  <= S_HUNT;
        err_to_q <= 1'b1;
      end else if (take) begin
        unique case (state_q)
          S_HUNT: begin
            if (rx_data == HEADER) state_q <= S_ADDR;
          end
          S_ADDR: begin
            addr_q  <= rx_data;
            xor_q   <= rx_data;
            state_q <= S_LEN;
          end
          S_LEN: begin
            if (!len_ok(rx_data)) begin
              err_fr_q <= 1'b1;
              state_q  <= S_HUNT;
            end else begin
              rem_q   <= rx_data[2:0];
              xor_q   <= xor_d;
              data_q  <= '0;
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            data_q <= data_d;
            xor_q  <= xor_d;
            rem_q  <= rem_q - 3'd1;
            if (rem_q == 3'd1) state_q <= S_CKSUM;
          end
          S_CKSUM: begin
            state_q <= S_HUNT;
            if (rx_data != xor_q) begin
              err_ck_q <= 1'b1;
            end else if (addr_q != BAUD_ADDR) begin
              cfg_addr_q <= addr_q;
              cfg_data_q <= data_q;
              cfg_wr_q   <= 1'b1;
            end else if (baud_ok) begin
              baud_q     <= data_q[BAUD_WIDTH-1:0];
              baud_upd_q <= 1'b1;
            end else begin
              err_fr_q <= 1'b1;
            end
          end
          default: state_q <= S_HUNT;
        endcase
      end
    end
  end

  assign rx_clr      = rx_clr_q;
  assign baud_var    = baud_q;
  assign baud_upd    = baud_upd_q;
  assign cfg_addr    = cfg_addr_q;
  assign cfg_data    = cfg_data_q;
  assign cfg_wr      = cfg_wr_q;
  assign busy        = (state_q != S_HUNT);
  assign err_cksum   = err_ck_q;
  assign err_frame   = err_fr_q;
  assign err_timeout = err_to_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_cmd_parser : directed + randomized frames against a frame-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_cmd_parser;

  localparam int BW       = 20;
  localparam int DEF_BAUD = 115200;
  localparam int MAXB     = 921600;
  localparam int TO       = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_rec = 1'b0;
  logic          rx_clr, baud_upd, cfg_wr, busy, err_cksum, err_frame, err_timeout;
  logic [BW-1:0] baud_var;
  logic [7:0]    cfg_addr;
  logic [31:0]   cfg_data;

  uart_cmd_parser #(
    .CLOCK_FREQ(100_000_000), .BAUD_WIDTH(BW), .DEFAULT_BAUD(DEF_BAUD),
    .MAX_BAUD(MAXB), .TIMEOUT_CYC(TO), .HEADER(8'h55), .BAUD_ADDR(8'hFE)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rec(rx_rec), .rx_clr(rx_clr),
    .baud_var(baud_var), .baud_upd(baud_upd), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_wr(cfg_wr), .busy(busy), .err_cksum(err_cksum),
    .err_frame(err_frame), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Pulse monitor: each one-cycle pulse is counted once on the falling edge.
  int n_wr = 0, n_ck = 0, n_fr = 0, n_to = 0, n_upd = 0, n_clr = 0;
  int wr_cyc = 0, fr_cyc = 0, to_cyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (rx_clr)      n_clr++;
      if (cfg_wr)      begin n_wr++; wr_cyc = cyc; end
      if (err_cksum)   n_ck++;
      if (err_frame)   begin n_fr++; fr_cyc = cyc; end
      if (err_timeout) begin n_to++; to_cyc = cyc; end
      if (baud_upd)    n_upd++;
    end
  end

  int total = 0, bad = 0;
  logic [7:0]    exp_addr = 8'h00;
  logic [31:0]   exp_data = 32'h0;
  logic [BW-1:0] exp_baud = BW'(DEF_BAUD);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Receiver model: rx_rec stays up through the clear cycle, then drops.
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    int k;
    rx_data = b;
    rx_rec  = 1'b1;
    k = 0;
    do begin tick(1); k++; end while (!rx_clr && k < 8);
    chk("accept", rx_clr, 1'b1);
    acc = cyc;
    tick(1);
    rx_rec = 1'b0;
    chk("clr_width", rx_clr, 1'b0);
    tick(gap);
  endtask

  task automatic run_frame(input logic [7:0] addr, input int len, input logic [31:0] val,
                           input logic [7:0] ck_flip, input string tag);
    logic [7:0]  q[$];
    logic [7:0]  ck;
    logic [31:0] v;
    int w0, c0, f0, u0, l0, t0, acc;
    int e_wr, e_ck, e_fr, e_up;
    v  = (len >= 4) ? val : (val & ((32'd1 << (8 * len)) - 32'd1));
    q  = {8'h55, addr, 8'(len)};
    ck = addr ^ 8'(len);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = 8'(v >> (8 * (len - 1 - i)));
      q.push_back(b);
      ck ^= b;
    end
    q.push_back(ck ^ ck_flip);
    e_wr = 0; e_ck = 0; e_fr = 0; e_up = 0;
    if (ck_flip != 8'h00) e_ck = 1;
    else if (addr != 8'hFE) begin e_wr = 1; exp_addr = addr; exp_data = v; end
    else if (v != 0 && v <= MAXB) begin e_up = 1; exp_baud = v[BW-1:0]; end
    else e_fr = 1;
    w0 = n_wr; c0 = n_ck; f0 = n_fr; u0 = n_upd; l0 = n_clr; t0 = n_to;
    acc = 0;
    foreach (q[i]) send_byte(q[i], $urandom_range(0, 2), acc);
    tick(2);
    chk({tag, ".wr"},    n_wr - w0, e_wr);
    chk({tag, ".ck"},    n_ck - c0, e_ck);
    chk({tag, ".fr"},    n_fr - f0, e_fr);
    chk({tag, ".upd"},   n_upd - u0, e_up);
    chk({tag, ".to"},    n_to - t0, 0);
    chk({tag, ".clr"},   n_clr - l0, q.size());
    chk({tag, ".addr"},  cfg_addr, exp_addr);
    chk({tag, ".data"},  cfg_data, exp_data);
    chk({tag, ".baud"},  baud_var, exp_baud);
    chk({tag, ".busy"},  busy, 1'b0);
    if (e_wr == 1) chk({tag, ".wr_cyc"}, wr_cyc, acc);
  endtask

  initial begin
    int acc, f0, l0, w0, t0, k;

    tick(3);
    chk("rst.clr",   rx_clr, 1'b0);
    chk("rst.wr",    cfg_wr, 1'b0);
    chk("rst.upd",   baud_upd, 1'b0);
    chk("rst.addr",  cfg_addr, 8'h00);
    chk("rst.data",  cfg_data, 32'h0);
    chk("rst.baud",  baud_var, BW'(DEF_BAUD));
    chk("rst.busy",  busy, 1'b0);
    chk("rst.errs",  {err_cksum, err_frame, err_timeout}, 3'b000);
    rst = 1'b1;
    tick(2);

    run_frame(8'h10, 2, 32'h1234, 8'h00, "good");
    run_frame(8'h10, 2, 32'h1234, 8'h01, "badck");
    run_frame(8'hFE, 3, 32'h01C200, 8'h00, "baud");
    run_frame(8'h22, 4, 32'hDEADBEEF, 8'h00, "newrate");

    // Stray bytes, then a frame with an illegal length.
    f0 = n_fr; l0 = n_clr; w0 = n_wr;
    send_byte(8'h00, 1, acc);
    send_byte(8'hFF, 0, acc);
    chk("stray.busy", busy, 1'b0);
    send_byte(8'h55, 0, acc);
    send_byte(8'h20, 1, acc);
    send_byte(8'h05, 0, acc);
    tick(2);
    chk("len.fr",     n_fr - f0, 1);
    chk("len.fr_cyc", fr_cyc, acc);
    chk("len.busy",   busy, 1'b0);
    chk("len.clr",    n_clr - l0, 5);
    chk("len.wr",     n_wr - w0, 0);

    // Partial frame abandoned mid-data.
    t0 = n_to; w0 = n_wr;
    send_byte(8'h55, 0, acc);
    send_byte(8'h10, 0, acc);
    send_byte(8'h04, 0, acc);
    send_byte(8'hAA, 0, acc);
    k = 0;
    while (n_to == t0 && k < TO + 50) begin tick(1); k++; end
    chk("to.count", n_to - t0, 1);
    chk("to.delay", to_cyc - acc, TO);
    tick(1);
    chk("to.busy",  busy, 1'b0);
    chk("to.wr",    n_wr - w0, 0);
    run_frame(8'h33, 4, 32'h0BADF00D, 8'h00, "after_to");

    for (int it = 0; it < 24; it++) begin
      logic [7:0]  a;
      logic [31:0] v;
      logic [7:0]  f;
      int          l;
      l = $urandom_range(1, 4);
      v = $urandom;
      a = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a = 8'hFE;
        l = 3;
        case ($urandom_range(0, 2))
          0:       v = $urandom_range(1, MAXB);
          1:       v = 32'd0;
          default: v = $urandom_range(MAXB + 1, 32'hFF_FFFF);
        endcase
      end
      f = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(a, l, v, f, "rand");
    end

    // Asynchronous reset mid-DATA with a non-default baud in place.
    run_frame(8'hFE, 3, 32'd9600, 8'h00, "baud9600");
    send_byte(8'h55, 0, acc);
    send_byte(8'h30, 0, acc);
    send_byte(8'h04, 0, acc);
    send_byte(8'h11, 0, acc);
    chk("pre_rst.busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst.baud", baud_var, BW'(DEF_BAUD));
    chk("arst.busy", busy, 1'b0);
    chk("arst.addr", cfg_addr, 8'h00);
    chk("arst.data", cfg_data, 32'h0);
    chk("arst.strb", {rx_clr, cfg_wr, baud_upd, err_cksum, err_frame, err_timeout}, 6'b0);
    exp_addr = 8'h00;
    exp_data = 32'h0;
    exp_baud = BW'(DEF_BAUD);
    tick(2);
    rst = 1'b1;
    tick(1);
    run_frame(8'h44, 1, 32'h7E, 8'h00, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
